modulo_divisor_programavel: RTL and testbench
=============================================

# modulo_divisor_programavel

Parametrised, runtime-programmable clock-enable divider and successor to the fixed ripple divider chain. A single synchronous counter in the system clock domain divides by any integer N (2 … 2^WIDTH−1). It produces a registered square-wave output `clock_div` and a one-cycle `tick` strobe. New divisors load without glitches at the period boundary. Downstream timing blocks (display multiplexing, debounce, FSM pacing) consume `tick` as a clock enable, not as a derived clock.

## Interface
- `WIDTH`, default 20: counter and divisor width.
- `DEFAULT_DIV`, default 524288: divisor active after reset; must satisfy 2 ≤ DEFAULT_DIV < 2^WIDTH.
- `clock` input 1: system clock, rising edge.
- `clear` input 1: asynchronous, active-low reset; 0 resets the block.
- `enable` input 1: 1 advances the counter each cycle; 0 freezes all state.
- `load` input 1: single-cycle request to capture `div_value` into the pending register.
- `div_value` input WIDTH: requested divisor N.
- `restart` input 1: synchronous; zeroes the counter and applies any pending divisor immediately.
- `clock_div` output 1: registered divided square wave, period N cycles (while enabled).
- `tick` output 1: registered one-cycle strobe, once per period.
- `load_pending` output 1: a captured divisor is waiting for the next boundary.

## Operation
- State:
  - `count` [WIDTH]
  - `div_act` [WIDTH]
  - `div_pend` [WIDTH]
  - `pend` flag
  - `clock_div` and `tick` registers
- Reset (`clear`=0, async): `count`=0, `div_act`=DEFAULT_DIV, `div_pend`=0, `pend`=0, `clock_div`=0, `tick`=0.
- Divisor clamp: any captured value < 2 (0 or 1) is stored as 2. No other range check.
- Load: `load`=1 sets `div_pend`=clamp(`div_value`) and `pend`=1, independent of `enable`. A second load before it is applied overwrites `div_pend`; only the last one counts.
- Enabled cycle, normal count: `count` < `div_act`−1 → `count`+1.
- Enabled cycle, wrap: `count`=`div_act`−1 → `count`=0.
  - If `pend`=1: `div_act`=`div_pend` and `pend`=0 on this same edge.
  - `tick`=1 for exactly the following cycle.
- After every enabled edge: `clock_div` = (new `count` ≥ H), with H = ceil(`div_act`/2) evaluated using the divisor in force after that edge.
  - Low for ceil(N/2) cycles, then high for floor(N/2) cycles.
  - N even → 50 % duty; N odd → low is one cycle longer.
- Enable low: `count`, `clock_div` and `div_act` hold; `tick`=0. `load` is still accepted.
- Restart (`restart`=1), takes priority over `enable` and the wrap:
  - `count`=0, `clock_div`=0, `tick`=0.
  - If `pend`=1: apply `div_pend` and clear `pend`.
- Load and wrap on the same edge: the wrap applies the *old* `div_pend` (if `pend` was set), and the new value becomes pending with `pend`=1.
- Load and restart on the same edge: the new `div_value` is applied immediately and `pend`=0.
- Defensive wrap: if `count` ≥ `div_act`−1, wrap to 0.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- First enabled edge after reset: `count`=1.
- `tick` rises in the cycle after the edge on which `count` wraps. The first tick comes N enabled edges after reset release.
- `clock_div` rises on the edge where `count` reaches H.
- `load_pending` goes to 1 on the edge after `load`. It clears on the wrap or restart edge that applies the value.
- Reset asserted mid-period aborts immediately: outputs go to their reset values asynchronously and any pending load is lost.
- Divisor change is glitch-free: the period in progress always completes with the old N, and the first period after the boundary uses the new N in full. Restart is the only deliberate exception.

## Structure
- Shared package `modulo_divisor_pkg`:
  - constant `DIV_MIN` = 2
  - clamp function `div_clamp(value, WIDTH)`
  - half-period function `div_half(N)` = (N+1)>>1
- One sub-module: `modulo_contador_modulo_n`, holding the counter with wrap, enable and restart, plus a terminal-count flag.
- The top level owns the pending/active divisor registers and the output registers.

## Test plan
- WIDTH=8, DEFAULT_DIV=4, enable=1 after reset → `clock_div` repeats 0,0,1,1, `tick` pulses every 4th cycle, first tick 4 cycles after release.
- load 5 at count=1 → current period finishes at 4 cycles, `load_pending`=1 until wrap, then `clock_div` repeats 0,0,0,1,1 and `tick` period is 5.
- load 0 and load 1 → behaves as N=2: `clock_div` toggles every cycle, `tick` every 2 cycles. Load 255 → period 255, low 128, high 127.
- enable low for 10 cycles mid-period → `count`/`clock_div` frozen, `tick`=0, resume completes the remaining cycles exactly. A load during the freeze is applied at the next wrap.
- load 6, then restart 2 cycles later → `count`=0, N=6 immediately, `load_pending`=0.
- Same-edge cases: load+wrap → old pending applied, new one pending. Load+restart → new value live immediately.
- `clear` pulsed low mid-period with a load pending → all outputs 0 asynchronously, divisor back to DEFAULT_DIV, pending discarded.

Source files
------------

// File: rtl/modulo_divisor_pkg.sv
// Shared constants and helpers for the programmable clock-enable divider.
// Helpers work on a 32-bit word; callers narrow the result to their own WIDTH (WIDTH <= 31).
package modulo_divisor_pkg;

    localparam int unsigned DIV_MIN = 2;

    typedef logic [31:0] div_word_t;

    // Truncate to the divisor width, then force degenerate divisors (0, 1) up to the minimum.
    function automatic div_word_t div_clamp(input div_word_t value, input int unsigned width);
        div_word_t masked;
        masked = (width >= 32) ? value
                               : (value & ((div_word_t'(1) << width) - div_word_t'(1)));
        return (masked < DIV_MIN) ? div_word_t'(DIV_MIN) : masked;
    endfunction

    // ceil(n/2): the count at which the square wave goes high.
    function automatic div_word_t div_half(input div_word_t n);
        logic [32:0] sum;
        sum = {1'b0, n} + 33'd1;
        return sum[32:1];
    endfunction

endpackage

// File: rtl/modulo_contador_modulo_n.sv
// Modulo-N counter with enable, synchronous restart and a terminal-count flag.
// Counts 0 .. div_act-1 and wraps; any count at or beyond the terminal value also wraps.
module modulo_contador_modulo_n
    import modulo_divisor_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic             restart,
    input  logic [WIDTH-1:0] div_act,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    // div_act is never below DIV_MIN, so the subtraction cannot underflow.
    assign terminal = (count >= div_act - WIDTH'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/modulo_divisor_programavel.sv
// Runtime-programmable clock-enable divider: registered square wave plus one-cycle tick.
// New divisors wait in a pending register and take effect at the period boundary or on restart.
module modulo_divisor_programavel
    import modulo_divisor_pkg::*;
#(
    parameter int          WIDTH       = 20,
    parameter int unsigned DEFAULT_DIV = 524288
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] div_value,
    input  logic             restart,
    output logic             clock_div,
    output logic             tick,
    output logic             load_pending
);

    localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] div_pend;
    logic [WIDTH-1:0] div_load;
    logic             pend;
    logic             terminal;
    logic             wrap;
    logic             high_next;
    div_word_t        count_inc;

    modulo_contador_modulo_n #(
        .WIDTH (WIDTH)
    ) u_contador (
        .clock    (clock),
        .clear    (clear),
        .enable   (enable),
        .restart  (restart),
        .div_act  (div_act),
        .count    (count),
        .terminal (terminal)
    );

    assign div_load  = WIDTH'(div_clamp(div_word_t'(div_value), WIDTH));
    assign wrap      = enable & ~restart & terminal;
    assign count_inc = div_word_t'(count) + div_word_t'(1);

    // Off the wrap the divisor is unchanged, so the comparison can use div_act directly;
    // on the wrap the new count is 0, which is always in the low phase.
    assign high_next = !terminal && (count_inc >= div_half(div_word_t'(div_act)));

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            div_act   <= DIV_RESET;
            div_pend  <= '0;
            pend      <= 1'b0;
            clock_div <= 1'b0;
            tick      <= 1'b0;
        end else begin
            if (load) begin
                div_pend <= div_load;
            end

            if (restart) begin
                clock_div <= 1'b0;
                tick      <= 1'b0;
                pend      <= 1'b0;
                if (load) begin
                    div_act <= div_load;
                end else if (pend) begin
                    div_act <= div_pend;
                end
            end else begin
                // The wrap consumes the divisor already pending; a same-edge load queues behind it.
                if (wrap && pend) begin
                    div_act <= div_pend;
                end
                if (load) begin
                    pend <= 1'b1;
                end else if (wrap) begin
                    pend <= 1'b0;
                end
                if (enable) begin
                    clock_div <= high_next;
                    tick      <= terminal;
                end else begin
                    tick <= 1'b0;
                end
            end
        end
    end

    assign load_pending = pend;

endmodule

// File: tb/tb_modulo_divisor_programavel.sv
// Self-checking bench: directed scenarios plus random traffic against a period-position model.
module tb_modulo_divisor_programavel;

    localparam int W   = 8;
    localparam int DEF = 4;

    logic         clock = 1'b0;
    logic         clear;
    logic         enable;
    logic         load;
    logic [W-1:0] div_value;
    logic         restart;
    logic         clock_div;
    logic         tick;
    logic         load_pending;

    modulo_divisor_programavel #(
        .WIDTH       (W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clock        (clock),
        .clear        (clear),
        .enable       (enable),
        .load         (load),
        .div_value    (div_value),
        .restart      (restart),
        .clock_div    (clock_div),
        .tick         (tick),
        .load_pending (load_pending)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference: position within the current period, active/pending divisor.
    int m_pos;
    int m_n;
    int m_pv;
    bit m_pend;
    bit m_cd;
    bit m_tk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int clamp_div(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_n = DEF; m_pv = 0; m_pend = 0; m_cd = 0; m_tk = 0;
    endtask

    task automatic model_edge();
        bit wrapped;
        wrapped = 0;
        if (restart) begin
            if (load) begin
                m_n = clamp_div(int'(div_value));
            end else if (m_pend) begin
                m_n = m_pv;
            end
            if (load) m_pv = clamp_div(int'(div_value));
            m_pend = 0;
            m_pos  = 0;
            m_cd   = 0;
            m_tk   = 0;
        end else begin
            if (enable) begin
                m_pos++;
                if (m_pos >= m_n) begin
                    m_pos   = 0;
                    wrapped = 1;
                    if (m_pend) begin
                        m_n    = m_pv;
                        m_pend = 0;
                    end
                end
            end
            if (load) begin
                m_pv   = clamp_div(int'(div_value));
                m_pend = 1;
            end
            if (enable) begin
                // Low for ceil(N/2) positions, high for the rest of the period.
                m_cd = (m_pos >= (m_n + 1) / 2);
                m_tk = wrapped;
            end else begin
                m_tk = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        check("clock_div", 32'(clock_div), 32'(m_cd));
        check("tick", 32'(tick), 32'(m_tk));
        check("load_pending", 32'(load_pending), 32'(m_pend));
    endtask

    task automatic idle(input int n);
        load = 0;
        restart = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input int v);
        load = 1;
        div_value = W'(v);
        cycle();
        load = 0;
    endtask

    // Advance until the model reaches the given period position; bounded.
    task automatic wait_pos(input int p);
        int budget;
        budget = 600;
        while (m_pos != p && budget > 0) begin
            cycle();
            budget--;
        end
        check("wait_pos_timeout", 32'(m_pos), 32'(p));
    endtask

    initial begin
        clear = 0; enable = 0; load = 0; restart = 0; div_value = '0;
        model_reset();
        #12;
        check("reset_clock_div", 32'(clock_div), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_pending", 32'(load_pending), 32'd0);
        @(posedge clock); #1;
        clear = 1;
        enable = 1;

        // Default divisor 4: 0,0,1,1 with a tick every 4th cycle.
        idle(12);

        // Load 5 while at position 1; current period finishes with N=4.
        wait_pos(1);
        do_load(5);
        idle(15);

        // Degenerate divisors clamp to 2; then the largest divisor.
        do_load(0);
        idle(8);
        do_load(1);
        idle(8);
        do_load(255);
        idle(520);
        do_load(4);
        idle(260);

        // Freeze mid-period with a load during the freeze.
        wait_pos(1);
        enable = 0;
        idle(4);
        do_load(3);
        idle(5);
        enable = 1;
        idle(12);

        // Load 6 then restart two cycles later.
        do_load(6);
        idle(1);
        restart = 1;
        cycle();
        restart = 0;
        idle(14);

        // Load coinciding with the wrap: old pending applied, new one pending.
        do_load(5);
        wait_pos(m_n - 1);
        do_load(7);
        idle(20);

        // Load coinciding with restart: new value live immediately.
        load = 1; restart = 1; div_value = W'(3);
        cycle();
        load = 0; restart = 0;
        idle(8);

        // Asynchronous clear mid-period with a load pending.
        do_load(9);
        idle(2);
        #2;
        clear = 0;
        #1;
        model_reset();
        check("clear_async_clock_div", 32'(clock_div), 32'd0);
        check("clear_async_tick", 32'(tick), 32'd0);
        check("clear_async_pending", 32'(load_pending), 32'd0);
        @(posedge clock); #1;
        check("clear_hold_pending", 32'(load_pending), 32'd0);
        clear = 1;
        idle(10);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            enable  = ($urandom % 8) != 0;
            load    = ($urandom % 16) == 0;
            restart = ($urandom % 40) == 0;
            div_value = (($urandom % 4) == 0) ? W'($urandom) : W'($urandom % 10);
            cycle();
        end
        load = 0; restart = 0; enable = 1;
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
